// File: rtl/uart_rx_fifo_pkg.sv
// Shared constants for the UART receive path: FSM encodings, default baud divisor
// and the mmio register map for the RX data and status registers.
package uart_rx_fifo_pkg;

  localparam int unsigned DATA_W               = 8;
  localparam int unsigned DEFAULT_CLKS_PER_BIT = 868;  // 100 MHz / 115200 baud

  localparam logic [31:0] UART_RX_DATA_ADDR = 32'h0000_1008;
  localparam logic [31:0] UART_RX_STAT_ADDR = 32'h0000_100C;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_STOP      = 3'd3,
    ST_WAIT_IDLE = 3'd4
  } rx_state_e;

endpackage

// File: rtl/uart_rx_fifo_if.sv
// mmio-side load/pop interface of the UART receiver: FIFO head, occupancy and error flags.
interface uart_rx_fifo_if
  import uart_rx_fifo_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 16
);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

  logic              rd_en_i;
  logic              clr_err_i;
  logic [DATA_W-1:0] data_o;
  logic              valid_o;
  logic [CNT_W-1:0]  count_o;
  logic              overrun_o;
  logic              frame_err_o;

  modport master (
    output rd_en_i, clr_err_i,
    input  data_o, valid_o, count_o, overrun_o, frame_err_o
  );

  modport slave (
    input  rd_en_i, clr_err_i,
    output data_o, valid_o, count_o, overrun_o, frame_err_o
  );
endinterface

// File: rtl/uart_rx_fifo_sync_fifo.sv
// First-word-fall-through synchronous FIFO; a push into a full FIFO is accepted
// only when a pop happens in the same cycle.
module uart_rx_fifo_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign count   = count_q;
  assign dout    = empty ? '0 : mem[rd_ptr_q];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr_q] <= din;
  end
endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with mid-bit sampling, buffered in a FWFT FIFO read by mmio.
// Holds the input synchroniser, the frame FSM, its counters and the sticky error flags.
module uart_rx_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int unsigned FIFO_DEPTH   = 16
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           uart_txd_i,
  uart_rx_fifo_if.slave  bus
);
  localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam logic [BAUD_W-1:0] BAUD_HALF = BAUD_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

  logic [1:0]        sync_q;
  logic              rx_s;
  rx_state_e         state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]        bit_q, bit_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              overrun_q, overrun_d;
  logic              frame_err_q, frame_err_d;
  logic              push, frame_set, overrun_set;
  logic [DATA_W-1:0] fifo_dout;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_full, fifo_empty;

  assign rx_s = sync_q[1];

  // Two-flop synchroniser; reset to the idle-high line level.
  always_ff @(posedge clk_i) begin
    if (rst_i) sync_q <= 2'b11;
    else       sync_q <= {sync_q[0], uart_txd_i};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      baud_q      <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      baud_q      <= baud_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    push      = 1'b0;
    frame_set = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!rx_s) begin
          state_d = ST_START;
          baud_d  = '0;
        end
      end
      ST_START: begin
        if (baud_q == BAUD_HALF) begin
          baud_d = '0;
          bit_d  = '0;
          state_d = rx_s ? ST_IDLE : ST_DATA;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      ST_DATA: begin
        if (baud_q == BAUD_LAST) begin
          baud_d  = '0;
          shift_d = {rx_s, shift_q[DATA_W-1:1]};
          if (bit_q == 3'd7) state_d = ST_STOP;
          else               bit_d   = bit_q + 3'd1;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      ST_STOP: begin
        if (baud_q == BAUD_LAST) begin
          baud_d = '0;
          if (rx_s) begin
            push    = 1'b1;
            state_d = ST_IDLE;
          end else begin
            frame_set = 1'b1;
            state_d   = ST_WAIT_IDLE;
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      ST_WAIT_IDLE: begin
        // Hold off through a break so a long low line cannot retrigger a start.
        if (rx_s) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Sticky flags: a new error in the same cycle as a clear wins.
  assign overrun_set = push && fifo_full && !bus.rd_en_i;

  always_comb begin
    overrun_d   = overrun_q;
    frame_err_d = frame_err_q;
    if (bus.clr_err_i) begin
      overrun_d   = 1'b0;
      frame_err_d = 1'b0;
    end
    if (overrun_set) overrun_d   = 1'b1;
    if (frame_set)   frame_err_d = 1'b1;
  end

  uart_rx_fifo_sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .push  (push),
    .pop   (bus.rd_en_i),
    .din   (shift_q),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign bus.data_o      = fifo_dout;
  assign bus.valid_o     = !fifo_empty;
  assign bus.count_o     = fifo_count;
  assign bus.overrun_o   = overrun_q;
  assign bus.frame_err_o = frame_err_q;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo with CLKS_PER_BIT=8 and FIFO_DEPTH=4.
module tb_uart_rx_fifo;
  localparam int unsigned CPB   = 8;
  localparam int unsigned DEPTH = 4;
  // In-frame tick on which the receiver samples the stop bit (2 sync + 1 idle detect).
  localparam int STOP_T = 2 + CPB / 2 + 9 * CPB;

  logic clk = 1'b0;
  logic rst;
  logic txd;
  int   n_checks = 0;
  int   n_fail   = 0;

  uart_rx_fifo_if #(.FIFO_DEPTH(DEPTH)) bus ();

  uart_rx_fifo #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .uart_txd_i (txd),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drives one 8N1 frame; rd_en_i is pulsed on in-frame tick pop_at (-1 for none).
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int pop_at);
    int bi;
    for (int t = 0; t < 10 * CPB; t++) begin
      bi = t / CPB;
      if (bi == 0)      txd = 1'b0;
      else if (bi == 9) txd = stop_bit;
      else              txd = b[bi-1];
      bus.rd_en_i = (t == pop_at);
      tick();
    end
    bus.rd_en_i = 1'b0;
  endtask

  task automatic pop_expect(input string tag, input logic [7:0] exp);
    check_eq(tag, 32'(bus.data_o), 32'(exp));
    bus.rd_en_i = 1'b1;
    tick();
    bus.rd_en_i = 1'b0;
  endtask

  task automatic clear_errors();
    bus.clr_err_i = 1'b1;
    tick();
    bus.clr_err_i = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_valid"},   32'(bus.valid_o),     32'd0);
    check_eq({tag, "_data"},    32'(bus.data_o),      32'd0);
    check_eq({tag, "_count"},   32'(bus.count_o),     32'd0);
    check_eq({tag, "_overrun"}, 32'(bus.overrun_o),   32'd0);
    check_eq({tag, "_frame"},   32'(bus.frame_err_o), 32'd0);
  endtask

  initial begin
    txd           = 1'b1;
    rst           = 1'b1;
    bus.rd_en_i   = 1'b0;
    bus.clr_err_i = 1'b0;
    repeat (3) tick();
    check_all_zero("reset");
    rst = 1'b0;
    tick();

    // Single frame 0xA5.
    send_frame(8'hA5, 1'b1, -1);
    check_eq("a5_valid",   32'(bus.valid_o),     32'd1);
    check_eq("a5_count",   32'(bus.count_o),     32'd1);
    check_eq("a5_overrun", 32'(bus.overrun_o),   32'd0);
    check_eq("a5_frame",   32'(bus.frame_err_o), 32'd0);
    pop_expect("a5_data", 8'hA5);
    check_eq("a5_pop_valid", 32'(bus.valid_o), 32'd0);
    check_eq("a5_pop_count", 32'(bus.count_o), 32'd0);
    check_eq("a5_pop_data",  32'(bus.data_o),  32'd0);

    // Pop on empty has no effect.
    bus.rd_en_i = 1'b1;
    tick();
    bus.rd_en_i = 1'b0;
    check_eq("empty_pop_count", 32'(bus.count_o), 32'd0);

    // Fill, then overflow with no pop.
    for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b1, -1);
    send_frame(8'h55, 1'b1, -1);
    check_eq("ovf_count",   32'(bus.count_o),   32'd4);
    check_eq("ovf_overrun", 32'(bus.overrun_o), 32'd1);
    pop_expect("ovf_pop1", 8'h01);
    pop_expect("ovf_pop2", 8'h02);
    pop_expect("ovf_pop3", 8'h03);
    pop_expect("ovf_pop4", 8'h04);
    check_eq("ovf_drained", 32'(bus.count_o), 32'd0);
    clear_errors();
    check_eq("ovf_cleared", 32'(bus.overrun_o), 32'd0);

    // Full FIFO with a pop on the exact stop-sample cycle of the fifth frame.
    for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b1, -1);
    send_frame(8'h55, 1'b1, STOP_T);
    check_eq("pp_count",   32'(bus.count_o),   32'd4);
    check_eq("pp_overrun", 32'(bus.overrun_o), 32'd0);
    pop_expect("pp_pop1", 8'h02);
    pop_expect("pp_pop2", 8'h03);
    pop_expect("pp_pop3", 8'h04);
    pop_expect("pp_pop4", 8'h55);
    check_eq("pp_drained", 32'(bus.count_o), 32'd0);

    // Framing error followed by a break, then a clean frame.
    send_frame(8'h3C, 1'b0, -1);
    repeat (30) tick();
    txd = 1'b1;
    repeat (12) tick();
    check_eq("fe_flag",  32'(bus.frame_err_o), 32'd1);
    check_eq("fe_count", 32'(bus.count_o),     32'd0);
    check_eq("fe_valid", 32'(bus.valid_o),     32'd0);
    send_frame(8'h7E, 1'b1, -1);
    check_eq("fe_next_count",  32'(bus.count_o),     32'd1);
    check_eq("fe_next_sticky", 32'(bus.frame_err_o), 32'd1);
    clear_errors();
    check_eq("fe_cleared", 32'(bus.frame_err_o), 32'd0);
    pop_expect("fe_next_data", 8'h7E);

    // Two-cycle glitch is rejected as a false start.
    txd = 1'b0;
    repeat (2) tick();
    txd = 1'b1;
    repeat (20) tick();
    check_all_zero("glitch");
    send_frame(8'h96, 1'b1, -1);
    check_eq("glitch_next_count", 32'(bus.count_o), 32'd1);
    pop_expect("glitch_next_data", 8'h96);

    // Reset during the fourth data bit of 0xFF with two bytes queued.
    send_frame(8'h11, 1'b1, -1);
    send_frame(8'h22, 1'b1, -1);
    check_eq("rst_pre_count", 32'(bus.count_o), 32'd2);
    txd = 1'b0;
    repeat (CPB) tick();
    txd = 1'b1;
    repeat (3 * CPB + CPB / 2) tick();
    rst = 1'b1;
    tick();
    check_all_zero("midrst");
    rst = 1'b0;
    repeat (10 * CPB) tick();
    check_eq("midrst_idle_count", 32'(bus.count_o), 32'd0);
    send_frame(8'h12, 1'b1, -1);
    check_eq("midrst_next_count", 32'(bus.count_o), 32'd1);
    pop_expect("midrst_next_data", 8'h12);
    check_eq("final_count", 32'(bus.count_o), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
